// File: rtl/quad_step_decoder.sv
// quad_step_decoder: synchronizes and glitch-filters a two-phase quadrature
// input pair, decodes Gray-code transitions into one-cycle step pulses with a
// direction bit, and maintains a loadable wrapping position count plus a
// sticky illegal-transition flag.
module quad_step_decoder #(
   parameter int SIZE = 4,
   parameter int FILT = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            a_in,
   input  logic            b_in,
   input  logic            load,
   input  logic [SIZE-1:0] data,
   input  logic            clr_err,
   output logic            step,
   output logic            up_dwn,
   output logic [SIZE-1:0] pos,
   output logic            err
);

   // Filter counter is 4 bits wide, enough for FILT up to 15.
   localparam logic [3:0] FC_LAST = 4'(FILT - 1);

   typedef enum logic [1:0] {
      MV_NONE,
      MV_UP,
      MV_DN,
      MV_ILL
   } move_e;

   // Bit 1 carries phase A, bit 0 carries phase B, so {A,B} reads naturally.
   logic [1:0] raw_vec;
   logic [1:0] s2_vec;
   logic [1:0] f_vec;

   assign raw_vec = {a_in, b_in};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_chan
         logic       s1_q;
         logic       s2_q;
         logic       f_q;
         logic       f_d;
         logic [3:0] fc_q;
         logic [3:0] fc_d;

         // Two-flop synchronizer; never reset so the line is tracked during reset.
         always_ff @(posedge clk) begin
            s1_q <= raw_vec[gi];
            s2_q <= s1_q;
         end

         // Accept a new level only after it has persisted for FILT cycles.
         always_comb begin
            f_d  = f_q;
            fc_d = fc_q;
            if (reset) begin
               f_d  = s2_q;
               fc_d = 4'd0;
            end else if (s2_q == f_q) begin
               fc_d = 4'd0;
            end else if (fc_q == FC_LAST) begin
               f_d  = s2_q;
               fc_d = 4'd0;
            end else begin
               fc_d = fc_q + 4'd1;
            end
         end

         // Filter state register.
         always_ff @(posedge clk) begin
            f_q  <= f_d;
            fc_q <= fc_d;
         end

         assign s2_vec[gi] = s2_q;
         assign f_vec[gi]  = f_q;
      end
   endgenerate

   // Successor of a state along the up (A leads B) sequence 00->10->11->01->00.
   function automatic logic [1:0] gray_next(input logic [1:0] s);
      logic [1:0] r;
      case (s)
         2'b00:   r = 2'b10;
         2'b10:   r = 2'b11;
         2'b11:   r = 2'b01;
         default: r = 2'b00;
      endcase
      return r;
   endfunction

   logic [1:0]      sp_q, sp_d;
   logic [SIZE-1:0] pos_q, pos_d;
   logic            step_q, step_d;
   logic            up_q, up_d;
   logic            err_q, err_d;
   move_e           move;

   // Classify the filtered state change since the previous cycle.
   always_comb begin
      move = MV_NONE;
      if (f_vec == sp_q) begin
         move = MV_NONE;
      end else if ((f_vec ^ sp_q) == 2'b11) begin
         move = MV_ILL;
      end else if (f_vec == gray_next(sp_q)) begin
         move = MV_UP;
      end else begin
         move = MV_DN;
      end
   end

   // Next-state for position, step pulse, direction and error flag.
   always_comb begin
      sp_d   = f_vec;
      pos_d  = pos_q;
      step_d = 1'b0;
      up_d   = up_q;
      err_d  = err_q;
      if (reset) begin
         // Previous state follows the synchronized line so release is quiet.
         sp_d  = s2_vec;
         pos_d = '0;
         up_d  = 1'b1;
         err_d = 1'b0;
      end else begin
         case (move)
            MV_UP: begin
               step_d = 1'b1;
               up_d   = 1'b1;
               pos_d  = pos_q + SIZE'(1);
            end
            MV_DN: begin
               step_d = 1'b1;
               up_d   = 1'b0;
               pos_d  = pos_q - SIZE'(1);
            end
            default: ;
         endcase
         // Load overrides the count but not the step/direction report.
         if (load) begin
            pos_d = data;
         end
         // A new illegal transition beats a simultaneous clear.
         if (move == MV_ILL) begin
            err_d = 1'b1;
         end else if (clr_err) begin
            err_d = 1'b0;
         end
      end
   end

   // Decoder state register.
   always_ff @(posedge clk) begin
      sp_q   <= sp_d;
      pos_q  <= pos_d;
      step_q <= step_d;
      up_q   <= up_d;
      err_q  <= err_d;
   end

   assign step   = step_q;
   assign up_dwn = up_q;
   assign pos    = pos_q;
   assign err    = err_q;

endmodule
